// File: rtl/hilo_seq_if.sv
// Request/response bundle between the issuing pipe and the HI/LO sequencer.
// The pipe is the master; the sequencer is the slave and owns busy/done/hi/lo.
interface hilo_seq_if;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output req_valid, req_op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  req_valid, req_op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_seq.sv
// Multi-cycle HI/LO sequencer: counted-latency multiply/accumulate, 32-step
// restoring divide with sign fixup, MTHI/MTLO, and the architectural HI/LO.
module hilo_seq #(
    parameter int MUL_CYCLES = 3
) (
    input  logic      clk,
    input  logic      rst,
    hilo_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [4:0] MUL_INIT = 5'(MUL_CYCLES - 1);

    state_t      r_state, w_state_nx;
    logic [2:0]  r_op, w_op_nx;
    logic [31:0] r_a, w_a_nx;
    logic [31:0] r_b, w_b_nx;
    logic [4:0]  r_cnt, w_cnt_nx;
    logic [31:0] r_rem, w_rem_nx;
    logic [31:0] r_quot, w_quot_nx;
    logic [31:0] r_hi, w_hi_nx;
    logic [31:0] r_lo, w_lo_nx;
    logic        r_busy, w_busy_nx;
    logic        r_done, w_done_nx;

    logic               w_signed;
    logic signed [32:0] w_a_ext;
    logic signed [32:0] w_b_ext;
    logic        [63:0] w_prod;
    logic        [63:0] w_acc;
    logic        [63:0] w_mul_res;
    logic        [31:0] w_dvs;
    logic        [32:0] w_rem_sh;
    logic               w_ge;
    logic        [31:0] w_sub;
    logic        [31:0] w_q_fix;
    logic        [31:0] w_r_fix;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] f_cneg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Magnitude of a 32-bit operand; unsigned operands pass through untouched.
    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
        return f_cneg(v, is_signed & v[31]);
    endfunction

    // Opcode bit 0 set means the unsigned variant for ops 0..7.
    assign w_signed = ~r_op[0];
    assign w_a_ext  = {w_signed & r_a[31], r_a};
    assign w_b_ext  = {w_signed & r_b[31], r_b};
    assign w_prod   = 64'(w_a_ext) * 64'(w_b_ext);
    assign w_acc    = {r_hi, r_lo};

    // Select the 64-bit multiply-class result from the accumulate mode.
    always_comb begin
        case (r_op[2:1])
            2'b10:   w_mul_res = w_acc + w_prod;
            2'b11:   w_mul_res = w_acc - w_prod;
            default: w_mul_res = w_prod;
        endcase
    end

    // The dividend magnitude shifts out of r_quot MSB-first while quotient bits shift in.
    assign w_dvs    = f_mag(r_b, w_signed);
    assign w_rem_sh = {r_rem, r_quot[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, w_dvs});
    assign w_sub    = w_rem_sh[31:0] - w_dvs;
    assign w_q_fix  = f_cneg(r_quot, w_signed & (r_a[31] ^ r_b[31]));
    assign w_r_fix  = f_cneg(r_rem, w_signed & r_a[31]);

    // Next-state and next-register logic; flush overrides every state.
    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_cnt_nx   = r_cnt;
        w_rem_nx   = r_rem;
        w_quot_nx  = r_quot;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        if (bus.flush) begin
            w_state_nx = S_IDLE;
            w_busy_nx  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_busy_nx = 1'b0;
                    if (bus.req_valid) begin
                        case (bus.req_op)
                            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                                w_op_nx    = bus.req_op[2:0];
                                w_a_nx     = bus.src_a;
                                w_b_nx     = bus.src_b;
                                w_cnt_nx   = MUL_INIT;
                                w_state_nx = S_MUL;
                                w_busy_nx  = 1'b1;
                            end
                            4'd2, 4'd3: begin
                                w_op_nx    = bus.req_op[2:0];
                                w_a_nx     = bus.src_a;
                                w_b_nx     = bus.src_b;
                                w_cnt_nx   = 5'd0;
                                w_rem_nx   = 32'd0;
                                w_quot_nx  = f_mag(bus.src_a, ~bus.req_op[0]);
                                w_state_nx = S_DIV;
                                w_busy_nx  = 1'b1;
                            end
                            4'd8: begin
                                w_hi_nx   = bus.src_a;
                                w_done_nx = 1'b1;
                            end
                            4'd9: begin
                                w_lo_nx   = bus.src_a;
                                w_done_nx = 1'b1;
                            end
                            default: begin
                                w_state_nx = S_IDLE;
                            end
                        endcase
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == 5'd0) begin
                        w_hi_nx    = w_mul_res[63:32];
                        w_lo_nx    = w_mul_res[31:0];
                        w_done_nx  = 1'b1;
                        w_busy_nx  = 1'b0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    w_rem_nx  = w_ge ? w_sub : w_rem_sh[31:0];
                    w_quot_nx = {r_quot[30:0], w_ge};
                    w_cnt_nx  = r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        w_state_nx = S_FIX;
                    end else begin
                        w_state_nx = S_DIV;
                    end
                end
                S_FIX: begin
                    // A zero divisor completes on time but leaves HI/LO alone.
                    if (r_b != 32'd0) begin
                        w_hi_nx = w_r_fix;
                        w_lo_nx = w_q_fix;
                    end else begin
                        w_hi_nx = r_hi;
                        w_lo_nx = r_lo;
                    end
                    w_done_nx  = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_busy_nx  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_cnt   <= 5'd0;
            r_rem   <= 32'd0;
            r_quot  <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_cnt   <= w_cnt_nx;
            r_rem   <= w_rem_nx;
            r_quot  <= w_quot_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: doc/hilo_seq.md
# hilo_seq

Multi-cycle HI/LO sequencer for the master pipe. It executes the operations the single-cycle ALUs do not handle: MULT/MULTU, DIV/DIVU, MADD/MADDU, MSUB/MSUBU and MTHI/MTLO. It owns the architectural HI and LO registers and stalls the issuing pipe through `busy` while an operation is in flight. Multiplies use a fixed-latency counted product; divides use an in-block 32-iteration restoring divider.

## Interface

Parameters:
- `MUL_CYCLES`, default 3: cycles from accept to HI/LO commit for multiply-class ops; legal range 1..8.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present on `req_op`/`src_a`/`src_b`.
- `req_op` in 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10–15 reserved.
- `src_a` in 32: rs operand (dividend, multiplicand, MTHI/MTLO data).
- `src_b` in 32: rt operand (divisor, multiplier).
- `flush` in 1: abort any in-flight op with no HI/LO write.
- `busy` out 1: operation in flight; pipe must hold its request.
- `done` out 1: one-cycle pulse, the cycle after HI/LO commit.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.

## Operation

- States:
  - IDLE: accepts requests.
  - MUL: counts down `MUL_CYCLES`.
  - DIV: 32 iterations.
  - FIX: signed sign-fixup and commit.
- IDLE with `req_valid`, no `flush`, legal op:
  - Latch operands and op.
  - Ops 0,1,4–7 go to MUL; ops 2,3 go to DIV.
  - MTHI/MTLO write `hi`/`lo` at the accept edge and stay in IDLE.
- Reserved `req_op` is ignored: no state change, no `done`.
- `req_valid` outside IDLE is ignored. The pipe holds it because `busy` is high.
- Signed ops sign-extend operands to 33 bits; unsigned ops zero-extend.
- Product is 64 bits.
  - MULT/MULTU: {hi,lo} = product.
  - MADD: {hi,lo} += product, modulo 2^64.
  - MSUB: {hi,lo} -= product, modulo 2^64.
  - Accumulation uses HI/LO as held at commit. There is no other writer in flight.
- Divide: 32 restoring iterations on operand magnitudes, one quotient bit per cycle. FIX then applies signs:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Result: lo = quotient, hi = remainder.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0 (natural wrap).
- Divide by zero: `done` pulses at the normal latency; HI/LO are left unchanged.
- `flush` has the highest priority. In any state it returns to IDLE at the next edge with no commit and no `done`.
  - `flush` with `req_valid` in IDLE drops the request, including MTHI/MTLO.
- Reset:
  - `hi` = 0, `lo` = 0, state IDLE, `busy` = 0, `done` = 0.
  - Reset mid-operation discards the operation.

## Timing

- Accept edge is E0; `busy` goes high in the cycle after E0.
- Multiply class:
  - `busy` is high for `MUL_CYCLES` cycles.
  - HI/LO are written at edge E`MUL_CYCLES`.
  - `done` and new `hi`/`lo` are visible in the following cycle; `busy` is low there.
- Divide class:
  - `busy` is high for 33 cycles (32 DIV plus 1 FIX).
  - Commit is at edge E33; `done` is high in the cycle after E33.
- MTHI/MTLO: `busy` is never asserted. The new value is visible and `done` is high in the cycle after E0.
- The `done` cycle is IDLE, so a new request there is accepted (back-to-back, zero bubble).
- `hi`/`lo` are registered outputs. While `busy` they show pre-operation values.

## Test plan

- Reset, then MULT with a = 0xFFFFFFFD, b = 7 and `MUL_CYCLES` = 3:
  - `busy` high for 3 cycles.
  - Next cycle: `done` = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV with a = 0xFFFFFFF9 (−7), b = 2:
  - `done` arrives 33 cycles after accept.
  - lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU with the same operands: lo = 0x7FFFFFFC, hi = 1.
- MTLO 0xFFFFFFFF and MTHI 0 back-to-back, then MADDU with a = 1, b = 1:
  - hi = 1, lo = 0.
  - Then MSUB with a = 1, b = 1: hi = 0, lo = 0xFFFFFFFF.
- DIVU with a = 100, b = 0, issued after MTHI 0x11 and MTLO 0x22:
  - `done` at cycle 33.
  - hi = 0x11, lo = 0x22 (unchanged).
- DIV started, `flush` asserted in busy cycle 10:
  - IDLE next cycle, `busy` = 0, no `done`, HI/LO unchanged.
  - A MULT issued in the following cycle completes normally.
- MULT committing with a DIV request presented in the `done` cycle:
  - DIV is accepted that edge.
  - Also: `rst` asserted mid-DIV gives hi = lo = 0, `busy` = 0 the next cycle.
